// File: rtl/mcache_nway.sv
// Set-associative page cache in front of ROM/RAM: whole-page fills, full-page
// DCache writes and dirty write-back, round-robin victim per set.
module mcache_nway #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_PAGE   = 32,
  parameter int unsigned ROM_TOP    = 16'h2000,
  parameter int unsigned BYTES      = 1024,
  parameter int unsigned WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pageI,
  input  logic [ADDR_WIDTH-1:0] pageD,
  input  logic                  startI,
  input  logic                  startD,
  input  logic                  writeReq,
  output logic                  launchI,
  output logic                  launchD,
  output logic                  busy,
  output logic                  ready,
  output logic [15:0]           data,
  output logic                  take,
  input  logic [15:0]           wdata,
  output logic                  err,
  output logic                  ram_start,
  output logic                  ram_we,
  output logic [15:0]           ram_page,
  output logic [7:0]            ram_i_byte,
  input  logic [7:0]            ram_o_byte,
  input  logic                  ram_ready,
  input  logic                  ram_busy,
  output logic                  rom_start,
  output logic [15:0]           rom_page,
  input  logic [7:0]            rom_data,
  input  logic                  rom_ready,
  input  logic                  rom_busy
);

  localparam int unsigned PAGE_WORDS = MEM_PAGE / 2;
  localparam int unsigned LINES      = BYTES / MEM_PAGE;
  localparam int unsigned SETS       = LINES / WAYS;
  localparam int unsigned SET_W      = (SETS > 1)  ? $clog2(SETS)  : 1;
  localparam int unsigned WAY_W      = (WAYS > 1)  ? $clog2(WAYS)  : 1;
  localparam int unsigned LINE_W     = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned BYTE_W     = $clog2(MEM_PAGE);
  localparam int unsigned WORD_W     = BYTE_W - 1;
  localparam logic [ADDR_WIDTH-1:0] ROM_LIM   = ADDR_WIDTH'(ROM_TOP / MEM_PAGE);
  localparam logic [WORD_W-1:0]     LAST_WORD = WORD_W'(PAGE_WORDS - 1);
  localparam logic [BYTE_W-1:0]     LAST_BYTE = BYTE_W'(MEM_PAGE - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_READ, S_WRITE} state_t;
  state_t state;

  logic [15:0]           mem     [2**(LINE_W+WORD_W)];
  logic [ADDR_WIDTH-1:0] tag_q   [2**LINE_W];
  logic                  valid_q [2**LINE_W];
  logic                  dirty_q [2**LINE_W];
  logic [WAY_W-1:0]      victim_q[2**SET_W];

  logic [ADDR_WIDTH-1:0] page_q;
  logic                  rw_q;
  logic [SET_W-1:0]      set_q;
  logic [LINE_W-1:0]     line_q;
  logic [WORD_W-1:0]     word_q;
  logic [BYTE_W-1:0]     byte_q;
  logic                  phase, xfer, got_all;
  logic [7:0]            hold_byte;

  logic                  hit, has_inv, is_rom, src_busy, src_ready;
  logic [LINE_W-1:0]     hit_line, miss_line;
  logic [WAY_W-1:0]      inv_way, miss_way;
  logic [7:0]            src_byte;

  function automatic logic [LINE_W-1:0] line_of(input logic [SET_W-1:0] s,
                                                 input logic [WAY_W-1:0] w);
    return LINE_W'(32'(s) * WAYS + 32'(w));
  endfunction

  function automatic logic [SET_W-1:0] set_of(input logic [ADDR_WIDTH-1:0] p);
    return SET_W'(32'(p) % SETS);
  endfunction

  function automatic logic [7:0] get_byte(input logic [LINE_W-1:0] ln,
                                          input logic [BYTE_W-1:0] b);
    logic [15:0] w;
    w = mem[{ln, b[BYTE_W-1:1]}];
    return b[0] ? w[7:0] : w[15:8];
  endfunction

  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    has_inv  = 1'b0;
    inv_way  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[line_of(set_q, WAY_W'(w))] && tag_q[line_of(set_q, WAY_W'(w))] == page_q
          && !hit) begin
        hit      = 1'b1;
        hit_line = line_of(set_q, WAY_W'(w));
      end
      if (!valid_q[line_of(set_q, WAY_W'(w))] && !has_inv) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    miss_way  = has_inv ? inv_way : victim_q[set_q];
    miss_line = line_of(set_q, miss_way);
    is_rom    = page_q < ROM_LIM;
    src_busy  = is_rom ? rom_busy  : ram_busy;
    src_ready = is_rom ? rom_ready : ram_ready;
    src_byte  = is_rom ? rom_data  : ram_o_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      launchI    <= 1'b0;
      launchD    <= 1'b0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      take       <= 1'b0;
      err        <= 1'b0;
      ram_start  <= 1'b0;
      rom_start  <= 1'b0;
      ram_we     <= 1'b0;
      data       <= '0;
      ram_i_byte <= '0;
      ram_page   <= '0;
      rom_page   <= '0;
      page_q     <= '0;
      rw_q       <= 1'b0;
      set_q      <= '0;
      line_q     <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      phase      <= 1'b0;
      xfer       <= 1'b0;
      got_all    <= 1'b0;
      hold_byte  <= '0;
      for (int unsigned i = 0; i < 2**LINE_W; i++) begin
        valid_q[LINE_W'(i)] <= 1'b0;
        dirty_q[LINE_W'(i)] <= 1'b0;
      end
      for (int unsigned i = 0; i < 2**SET_W; i++) victim_q[SET_W'(i)] <= '0;
    end else begin
      launchI   <= 1'b0;
      launchD   <= 1'b0;
      ready     <= 1'b0;
      take      <= 1'b0;
      err       <= 1'b0;
      ram_start <= 1'b0;
      rom_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (startD) begin
            page_q  <= pageD;
            set_q   <= set_of(pageD);
            rw_q    <= writeReq;
            launchD <= 1'b1;
            busy    <= 1'b1;
            state   <= S_LOOKUP;
          end else if (startI) begin
            page_q  <= pageI;
            set_q   <= set_of(pageI);
            rw_q    <= 1'b0;
            launchI <= 1'b1;
            busy    <= 1'b1;
            state   <= S_LOOKUP;
          end else begin
            busy <= 1'b0;
          end
        end
        S_LOOKUP: begin
          word_q  <= '0;
          byte_q  <= '0;
          phase   <= 1'b0;
          xfer    <= 1'b0;
          got_all <= 1'b0;
          if (hit) begin
            line_q <= hit_line;
            state  <= rw_q ? S_WRITE : S_READ;
          end else begin
            line_q          <= miss_line;
            victim_q[set_q] <= WAY_W'((32'(victim_q[set_q]) + 1) % WAYS);
            state           <= (valid_q[miss_line] && dirty_q[miss_line]) ? S_EVICT : S_FILL;
          end
        end
        S_EVICT: begin
          if (!xfer) begin
            if (!ram_busy) begin
              ram_start  <= 1'b1;
              ram_we     <= 1'b1;
              ram_page   <= 16'(tag_q[line_q]);
              ram_i_byte <= get_byte(line_q, '0);
              byte_q     <= '0;
              xfer       <= 1'b1;
            end
          end else if (ram_ready) begin
            if (byte_q == LAST_BYTE) begin
              dirty_q[line_q] <= 1'b0;
              byte_q          <= '0;
              xfer            <= 1'b0;
              state           <= S_FILL;
            end else begin
              byte_q     <= byte_q + 1'b1;
              ram_i_byte <= get_byte(line_q, byte_q + 1'b1);
            end
          end
        end
        S_FILL: begin
          // Line becomes valid only once the source has dropped busy.
          if (!xfer) begin
            if (!src_busy) begin
              if (is_rom) begin
                rom_start <= 1'b1;
                rom_page  <= 16'(page_q);
              end else begin
                ram_start <= 1'b1;
                ram_we    <= 1'b0;
                ram_page  <= 16'(page_q);
              end
              xfer    <= 1'b1;
              got_all <= 1'b0;
              byte_q  <= '0;
            end
          end else if (!got_all) begin
            if (src_ready) begin
              if (!byte_q[0]) hold_byte <= src_byte;
              else mem[{line_q, byte_q[BYTE_W-1:1]}] <= {hold_byte, src_byte};
              byte_q <= byte_q + 1'b1;
              if (byte_q == LAST_BYTE) got_all <= 1'b1;
            end
          end else if (!src_busy) begin
            tag_q[line_q]   <= page_q;
            valid_q[line_q] <= 1'b1;
            dirty_q[line_q] <= 1'b0;
            xfer            <= 1'b0;
            got_all         <= 1'b0;
            word_q          <= '0;
            phase           <= 1'b0;
            state           <= rw_q ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            ready  <= 1'b1;
            data   <= mem[{line_q, word_q}];
            word_q <= word_q + 1'b1;
            phase  <= 1'b0;
            if (word_q == LAST_WORD) state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (!phase) begin
            take  <= 1'b1;
            phase <= 1'b1;
            if (word_q == '0 && is_rom) err <= 1'b1;
          end else begin
            if (!is_rom) begin
              mem[{line_q, word_q}] <= wdata;
              dirty_q[line_q]       <= 1'b1;
            end
            word_q <= word_q + 1'b1;
            phase  <= 1'b0;
            if (word_q == LAST_WORD) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcache_nway.sv
// Scoreboard bench for mcache_nway: directed page traffic against ROM/RAM models,
// monitors pop expected data, starts, launches and write-back bytes.
module tb_mcache_nway;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pageI, pageD;
  logic        startI, startD, writeReq;
  logic        launchI, launchD, busy, ready, take, err;
  logic [15:0] data, wdata;
  logic        ram_start, ram_we, ram_ready, ram_busy;
  logic [15:0] ram_page, rom_page;
  logic [7:0]  ram_i_byte, ram_o_byte, rom_data;
  logic        rom_start, rom_ready, rom_busy;

  mcache_nway #(.ADDR_WIDTH(16), .MEM_PAGE(32), .ROM_TOP(16'h2000), .BYTES(1024), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .pageI(pageI), .pageD(pageD), .startI(startI), .startD(startD),
    .writeReq(writeReq), .launchI(launchI), .launchD(launchD), .busy(busy), .ready(ready),
    .data(data), .take(take), .wdata(wdata), .err(err), .ram_start(ram_start), .ram_we(ram_we),
    .ram_page(ram_page), .ram_i_byte(ram_i_byte), .ram_o_byte(ram_o_byte), .ram_ready(ram_ready),
    .ram_busy(ram_busy), .rom_start(rom_start), .rom_page(rom_page), .rom_data(rom_data),
    .rom_ready(rom_ready), .rom_busy(rom_busy));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int take_cnt = 0, err_cnt = 0;
  logic [15:0] wd_next = '0;
  logic [15:0] exp_data[$];
  logic [17:0] exp_start[$];   // {kind, page}: 0 ROM, 1 RAM fill, 2 RAM write-back
  logic        exp_launch[$];  // 1 = D
  logic [7:0]  exp_wb[$];
  logic [7:0]  ram_mem[int];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with empty expectation queue", name);
  endtask

  function automatic logic [7:0] rom_byte(input int a);
    return 8'(a) + 8'(a >> 8);
  endfunction

  function automatic logic [7:0] ram_byte(input int a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return ~8'(a) ^ 8'(a >> 8);
  endfunction

  task automatic push_page(input logic [15:0] pg);
    for (int k = 0; k < 16; k++) begin
      int a;
      a = int'(pg) * 32 + 2 * k;
      if (pg < 16'h0100) exp_data.push_back({rom_byte(a), rom_byte(a + 1)});
      else exp_data.push_back({ram_byte(a), ram_byte(a + 1)});
    end
  endtask

  // Monitors and write-data driver
  always @(negedge clk) begin
    if (!rst) begin
      if (ready) begin
        if (exp_data.size() == 0) unexpected("ready");
        else chk("data", 32'(data), 32'(exp_data.pop_front()));
      end
      if (rom_start) begin
        if (exp_start.size() == 0) unexpected("rom_start");
        else chk("rom_start", 32'({2'd0, rom_page}), 32'(exp_start.pop_front()));
      end
      if (ram_start) begin
        if (exp_start.size() == 0) unexpected("ram_start");
        else chk("ram_start", 32'({ram_we ? 2'd2 : 2'd1, ram_page}), 32'(exp_start.pop_front()));
      end
      if (launchI || launchD) begin
        chk("launch_both", 32'(launchI & launchD), 32'(0));
        if (exp_launch.size() == 0) unexpected("launch");
        else chk("launch_sel", 32'(launchD), 32'(exp_launch.pop_front()));
      end
      if (err) begin
        err_cnt++;
        chk("err_with_take", 32'(take), 32'(1));
      end
      if (take) begin
        wdata = wd_next;
        wd_next++;
        take_cnt++;
      end
    end
  end

  // ROM model: one byte every two cycles, abandons on reset
  initial begin
    rom_busy = 1'b0; rom_ready = 1'b0; rom_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rom_start && !rst) begin
        logic [15:0] pg;
        pg = rom_page;
        rom_busy = 1'b1;
        for (int b = 0; b < 32; b++) begin
          @(posedge clk); #1;
          if (rst) break;
          rom_ready = 1'b1;
          rom_data  = rom_byte(int'(pg) * 32 + b);
          @(posedge clk); #1;
          rom_ready = 1'b0;
          if (rst) break;
        end
        rom_ready = 1'b0;
        rom_busy  = 1'b0;
      end
    end
  end

  // RAM model: fill and write-back; write-back bytes checked against exp_wb
  initial begin
    ram_busy = 1'b0; ram_ready = 1'b0; ram_o_byte = '0;
    forever begin
      @(posedge clk); #1;
      if (ram_start && !rst) begin
        logic        we;
        logic [15:0] pg;
        we = ram_we;
        pg = ram_page;
        ram_busy = 1'b1;
        for (int b = 0; b < 32; b++) begin
          @(posedge clk); #1;
          if (rst) break;
          ram_ready = 1'b1;
          if (we) begin
            if (exp_wb.size() == 0) unexpected("wb_byte");
            else chk("wb_byte", 32'(ram_i_byte), 32'(exp_wb.pop_front()));
            ram_mem[int'(pg) * 32 + b] = ram_i_byte;
          end else begin
            ram_o_byte = ram_byte(int'(pg) * 32 + b);
          end
          @(posedge clk); #1;
          ram_ready = 1'b0;
          if (rst) break;
        end
        ram_ready = 1'b0;
        ram_busy  = 1'b0;
      end
    end
  end

  task automatic check_reset();
    chk("rst_busy", 32'(busy), 0);           chk("rst_ready", 32'(ready), 0);
    chk("rst_take", 32'(take), 0);           chk("rst_err", 32'(err), 0);
    chk("rst_launchI", 32'(launchI), 0);     chk("rst_launchD", 32'(launchD), 0);
    chk("rst_ram_start", 32'(ram_start), 0); chk("rst_rom_start", 32'(rom_start), 0);
    chk("rst_ram_we", 32'(ram_we), 0);       chk("rst_data", 32'(data), 0);
    chk("rst_ram_i_byte", 32'(ram_i_byte), 0);
    chk("rst_ram_page", 32'(ram_page), 0);   chk("rst_rom_page", 32'(rom_page), 0);
  endtask

  task automatic wait_launch(input bit isD);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (isD ? launchD : launchI) begin seen = 1'b1; break; end
    end
    if (!seen) unexpected(isD ? "launchD_timeout" : "launchI_timeout");
    if (isD) startD = 1'b0; else startI = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy) begin done = 1'b1; break; end
    end
    if (!done) unexpected("busy_timeout");
  endtask

  task automatic req(input bit isD, input bit we, input logic [15:0] pg);
    if (isD) begin pageD = pg; writeReq = we; startD = 1'b1; end
    else begin pageI = pg; startI = 1'b1; end
    wait_launch(isD);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; pageI = '0; pageD = '0; startI = 1'b0; startD = 1'b0;
    writeReq = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b0;

    // 1: cold ROM read
    exp_start.push_back({2'd0, 16'h0010}); exp_launch.push_back(1'b0); push_page(16'h0010);
    req(1'b0, 1'b0, 16'h0010);

    // 2: hit, no start, first ready 3 cycles after launch
    exp_launch.push_back(1'b0); push_page(16'h0010);
    pageI = 16'h0010; startI = 1'b1;
    wait_launch(1'b0);
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    chk("hit_latency", 32'(cyc - t0), 32'(3));
    wait_idle();

    // 3: simultaneous requests, D first then I
    exp_launch.push_back(1'b1); exp_launch.push_back(1'b0);
    exp_start.push_back({2'd0, 16'h0011});
    push_page(16'h0011); push_page(16'h0010);
    pageD = 16'h0011; writeReq = 1'b0; pageI = 16'h0010;
    startD = 1'b1; startI = 1'b1;
    wait_launch(1'b1);
    wait_launch(1'b0);
    wait_idle();

    // 4: RAM write then set-0 pressure forces write-back of page 0x300
    take_cnt = 0; err_cnt = 0; wd_next = '0;
    exp_launch.push_back(1'b1); exp_start.push_back({2'd1, 16'h0300});
    req(1'b1, 1'b1, 16'h0300);
    chk("takes_ram", 32'(take_cnt), 32'(16));
    chk("err_ram", 32'(err_cnt), 32'(0));
    for (int k = 0; k < 16; k++) begin
      exp_wb.push_back(8'h00); exp_wb.push_back(8'(k));
    end
    exp_start.push_back({2'd1, 16'h0310}); exp_start.push_back({2'd2, 16'h0300});
    exp_start.push_back({2'd1, 16'h0320}); exp_start.push_back({2'd1, 16'h0330});
    exp_start.push_back({2'd1, 16'h0340});
    for (int p = 1; p <= 4; p++) begin
      exp_launch.push_back(1'b0);
      push_page(16'h0300 + 16'(p * 16));
      req(1'b0, 1'b0, 16'h0300 + 16'(p * 16));
    end
    chk("wb_drained", 32'(exp_wb.size()), 32'(0));
    exp_start.push_back({2'd1, 16'h0300}); exp_launch.push_back(1'b0);
    for (int k = 0; k < 16; k++) exp_data.push_back(16'(k));
    req(1'b0, 1'b0, 16'h0300);

    // 5: write to ROM page drops data and flags err
    take_cnt = 0; err_cnt = 0; wd_next = 16'hA5A5;
    exp_launch.push_back(1'b1); exp_start.push_back({2'd0, 16'h0020});
    req(1'b1, 1'b1, 16'h0020);
    chk("takes_rom", 32'(take_cnt), 32'(16));
    chk("err_rom", 32'(err_cnt), 32'(1));
    exp_launch.push_back(1'b0); push_page(16'h0020);
    req(1'b0, 1'b0, 16'h0020);

    // 6: reset during a fill, then refetch
    exp_launch.push_back(1'b0); exp_start.push_back({2'd0, 16'h0050});
    pageI = 16'h0050; startI = 1'b1;
    wait_launch(1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    exp_launch.push_back(1'b0); exp_start.push_back({2'd0, 16'h0050}); push_page(16'h0050);
    req(1'b0, 1'b0, 16'h0050);

    repeat (4) @(posedge clk);
    chk("data_drained", 32'(exp_data.size()), 32'(0));
    chk("start_drained", 32'(exp_start.size()), 32'(0));
    chk("launch_drained", 32'(exp_launch.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
